// File: rtl/fp16_mul_pkg.sv
// Shared fp16 definitions for the multiplier arbiter slice.
package fp16_mul_pkg;

   localparam int          FP16_MUL_LAT = 5;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [15:0] FP16_INF     = 16'h7C00;

   typedef logic [15:0] fp16_t;

endpackage

// File: rtl/fp16_multiplier.sv
// Pipelined fp16 multiplier: fixed FP16_MUL_LAT latency, no stall, no valid, no reset.
// Round-to-nearest-even; subnormal inputs and results flush to signed zero.
module fp16_multiplier
   import fp16_mul_pkg::*;
(
   input  logic  clk,
   input  fp16_t a,
   input  fp16_t b,
   output fp16_t out
);

   fp16_t              prod;
   fp16_t              stage [FP16_MUL_LAT];
   logic               sign;
   logic [4:0]         ea, eb;
   logic [9:0]         ma, mb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [21:0]        p;
   logic signed [7:0]  e;
   logic [10:0]        m_rnd;
   logic               guard, sticky;

   // Combinational product with special-case handling and rounding
   always_comb begin
      sign   = a[15] ^ b[15];
      ea     = a[14:10];
      eb     = b[14:10];
      ma     = a[9:0];
      mb     = b[9:0];
      a_nan  = (ea == 5'h1F) && (ma != 10'd0);
      b_nan  = (eb == 5'h1F) && (mb != 10'd0);
      a_inf  = (ea == 5'h1F) && (ma == 10'd0);
      b_inf  = (eb == 5'h1F) && (mb == 10'd0);
      a_zero = (ea == 5'd0);
      b_zero = (eb == 5'd0);
      p      = 22'({1'b1, ma}) * 22'({1'b1, mb});
      e      = $signed(8'(ea)) + $signed(8'(eb)) - 8'sd15;
      if (p[21]) begin
         m_rnd  = {1'b0, p[20:11]};
         guard  = p[10];
         sticky = |p[9:0];
         e      = e + 8'sd1;
      end else begin
         m_rnd  = {1'b0, p[19:10]};
         guard  = p[9];
         sticky = |p[8:0];
      end
      if (guard && (sticky || m_rnd[0])) begin
         m_rnd = m_rnd + 11'd1;
      end
      if (m_rnd[10]) begin
         m_rnd = 11'd0;
         e     = e + 8'sd1;
      end
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         prod = FP16_QNAN;
      end else if (a_inf || b_inf) begin
         prod = {sign, FP16_INF[14:0]};
      end else if (a_zero || b_zero) begin
         prod = {sign, 15'd0};
      end else if (e >= 8'sd31) begin
         prod = {sign, FP16_INF[14:0]};
      end else if (e <= 8'sd0) begin
         prod = {sign, 15'd0};
      end else begin
         prod = {sign, e[4:0], m_rnd[9:0]};
      end
   end

   // Delay line that gives the product its fixed latency
   always_ff @(posedge clk) begin
      stage[0] <= prod;
      for (int i = 1; i < FP16_MUL_LAT; i++) begin
         stage[i] <= stage[i-1];
      end
   end

   assign out = stage[FP16_MUL_LAT-1];

endmodule

// File: rtl/fp16_rsp_fifo.sv
// Synchronous response FIFO with registered storage and an occupancy count.
// Push while full is accepted only together with a pop.
module fp16_rsp_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_incr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   // Qualify push/pop against current occupancy
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
   end

   // Storage, pointers and count; storage is cleared so the head reads zero after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_incr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_incr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 multiplier among NUM_REQ requesters.
// Credits (fifo occupancy + in-flight ops) guarantee every result has a FIFO slot.
// Optional FP16_MUL_ARB_PERF_EN adds saturating issue/stall counters.
module fp16_mul_arbiter
   import fp16_mul_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MUL_LAT   = FP16_MUL_LAT,
   parameter int RSP_DEPTH = 8,
   parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*16-1:0]   req_a,
   input  logic [NUM_REQ*16-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [15:0]             rsp_data,
   output logic [IDW-1:0]          rsp_id
`ifdef FP16_MUL_ARB_PERF_EN
   ,
   output logic [31:0]             perf_issue_cnt,
   output logic [31:0]             perf_stall_cnt
`endif
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int FW = 16 + IDW;

   if (RSP_DEPTH < MUL_LAT) begin : g_depth_check
      $error("fp16_mul_arbiter: RSP_DEPTH must be >= MUL_LAT");
   end
   if (MUL_LAT != FP16_MUL_LAT) begin : g_lat_check
      $error("fp16_mul_arbiter: MUL_LAT must match the multiplier latency");
   end

   logic [IDW-1:0] rr_ptr, grant_idx, cand;
   logic           grant_found, issue_ok, issue, completion, pop;
   logic [MUL_LAT-1:0] valid_pipe;
   logic [IDW-1:0] id_pipe [MUL_LAT];
   logic [CW-1:0]  inflight, fifo_count;
   fp16_t          mul_a, mul_b, mul_out;
   logic [FW-1:0]  head_data;
   logic           fifo_empty;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Credit check, ready generation and operand steering into the multiplier
   always_comb begin
      issue_ok  = (int'(fifo_count) + int'(inflight)) < RSP_DEPTH;
      issue     = grant_found && issue_ok;
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (issue) begin
         req_ready[grant_idx] = 1'b1;
         mul_a = req_a[16*int'(grant_idx) +: 16];
         mul_b = req_b[16*int'(grant_idx) +: 16];
      end
   end

   // Pointer, valid/ID tracking pipes and in-flight count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= IDW'(NUM_REQ - 1);
         valid_pipe <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            id_pipe[i] <= '0;
         end
         inflight   <= '0;
      end else begin
         if (issue) begin
            rr_ptr <= grant_idx;
         end
         valid_pipe[0] <= issue;
         id_pipe[0]    <= issue ? grant_idx : '0;
         for (int i = 1; i < MUL_LAT; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            id_pipe[i]    <= id_pipe[i-1];
         end
         case ({issue, completion})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   assign completion = valid_pipe[MUL_LAT-1];
   assign pop        = !fifo_empty && rsp_ready;
   assign rsp_valid  = !fifo_empty;
   assign rsp_data   = head_data[FW-1:IDW];
   assign rsp_id     = head_data[IDW-1:0];

   fp16_multiplier u_mul (
      .clk (clk),
      .a   (mul_a),
      .b   (mul_b),
      .out (mul_out)
   );

   fp16_rsp_fifo #(
      .WIDTH (FW),
      .DEPTH (RSP_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (completion),
      .push_data ({mul_out, id_pipe[MUL_LAT-1]}),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

`ifdef FP16_MUL_ARB_PERF_EN
   // Saturating counters for issues and for cycles where requests wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if ((|req_valid) && !issue && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Testbench for fp16_mul_arbiter: directed vectors, a per-cycle behavioural
// model (queues of in-flight and buffered results) and literal spot checks.
module tb_fp16_mul_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int MUL_LAT   = 5;
   localparam int RSP_DEPTH = 8;
   localparam int IDW       = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_a = '0;
   logic [NUM_REQ*16-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [15:0]           rsp_data;
   logic [IDW-1:0]        rsp_id;
`ifdef FP16_MUL_ARB_PERF_EN
   logic [31:0]           perf_issue_cnt;
   logic [31:0]           perf_stall_cnt;
`endif

   int assert_count = 0;
   int fail_count   = 0;

   fp16_mul_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MUL_LAT   (MUL_LAT),
      .RSP_DEPTH (RSP_DEPTH),
      .IDW       (IDW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef FP16_MUL_ARB_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ready);
      req_valid = valid;
      rsp_ready = ready;
   endtask

   task automatic setOperands(input int idx, input logic [15:0] a, input logic [15:0] b);
      req_a[16*idx +: 16] = a;
      req_b[16*idx +: 16] = b;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      stepCycle();
      stepCycle();
      rst = 1'b0;
   endtask

   // Hand-computed fp16 products for every operand pair the stimulus uses; bit 16 = known
   function automatic logic [16:0] refProduct(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         {16'h3C00, 16'h4000}: return {1'b1, 16'h4000};
         {16'h4200, 16'h4400}: return {1'b1, 16'h4A00};
         {16'h3C00, 16'hBC00}: return {1'b1, 16'hBC00};
         {16'h7C00, 16'h0000}: return {1'b1, 16'h7E00};
         {16'h7BFF, 16'h7BFF}: return {1'b1, 16'h7C00};
         {16'h3C00, 16'h3C00}: return {1'b1, 16'h3C00};
         default:              return {1'b0, 16'h0000};
      endcase
   endfunction

   // Behavioural model state: round-robin pointer, in-flight ops with due edge, response queue
   typedef struct {
      logic [15:0]    data;
      logic [IDW-1:0] id;
      int             due;
   } op_t;

   op_t                m_inflight [$];
   op_t                m_fifo     [$];
   int                 m_ptr = NUM_REQ - 1;
   int                 m_cyc = 0;
   int                 m_grant;
   bit                 m_issue, m_pop;
   logic [15:0]        m_a, m_b;
   logic [16:0]        m_prod;
   logic [NUM_REQ-1:0] m_ready;

   // Per-cycle compare at the falling edge, model advance at the rising edge
   always begin
      @(negedge clk);
      m_issue = 1'b0;
      m_pop   = 1'b0;
      if (!rst) begin
         m_grant = -1;
         m_ready = '0;
         if (RSP_DEPTH - m_fifo.size() - m_inflight.size() > 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               if (m_grant < 0 && req_valid[(m_ptr + k) % NUM_REQ]) begin
                  m_grant = (m_ptr + k) % NUM_REQ;
               end
            end
         end
         if (m_grant >= 0) begin
            m_ready[m_grant] = 1'b1;
            m_issue = 1'b1;
            m_a = req_a[16*m_grant +: 16];
            m_b = req_b[16*m_grant +: 16];
         end
         checkOutput("req_ready", 32'(req_ready), 32'(m_ready));
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_fifo.size() > 0));
         if (m_fifo.size() > 0) begin
            checkOutput("rsp_data", 32'(rsp_data), 32'(m_fifo[0].data));
            checkOutput("rsp_id", 32'(rsp_id), 32'(m_fifo[0].id));
            m_pop = rsp_ready;
         end
         checkOutput("fifo_count", 32'(u_dut.fifo_count), 32'(m_fifo.size()));
         checkOutput("fifo_no_overflow", 32'(u_dut.fifo_count <= RSP_DEPTH), 32'd1);
      end
      @(posedge clk);
      if (rst) begin
         m_inflight.delete();
         m_fifo.delete();
         m_ptr = NUM_REQ - 1;
      end else begin
         m_cyc++;
         if (m_pop) begin
            void'(m_fifo.pop_front());
         end
         while (m_inflight.size() > 0 && m_inflight[0].due == m_cyc) begin
            m_fifo.push_back(m_inflight.pop_front());
         end
         if (m_issue) begin
            m_prod = refProduct(m_a, m_b);
            checkOutput("operand_pair_known", 32'(m_prod[16]), 32'd1);
            m_inflight.push_back('{data: m_prod[15:0], id: IDW'(m_grant), due: m_cyc + MUL_LAT});
            m_ptr = m_grant;
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [15:0]        exp_data [4];
   logic [15:0]        got_data [$];
   logic [IDW-1:0]     got_id   [$];
   logic [NUM_REQ-1:0] exp_ready;
   int                 xfers, issues;
   bit                 resumed, found;

   // Directed test sequence
   initial begin
      exp_data[0] = 16'h4A00;
      exp_data[1] = 16'hBC00;
      exp_data[2] = 16'h7E00;
      exp_data[3] = 16'h7C00;

      stepCycle();
      stepCycle();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
      stepCycle();

      // Test 1: single op, response exactly 6 cycles after transfer
      setOperands(0, 16'h3C00, 16'h4000);
      applyStimulus(4'b0001, 1'b1);
      @(negedge clk);
      checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
      stepCycle();
      applyStimulus(4'b0000, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checkOutput("t1_rsp_valid_latency", 32'(rsp_valid), 32'(k == 6));
         if (k == 6) begin
            checkOutput("t1_rsp_data", 32'(rsp_data), 32'h4000);
            checkOutput("t1_rsp_id", 32'(rsp_id), 32'd0);
         end
         stepCycle();
      end

      // Test 2: four requesters valid every cycle, round-robin order
      doReset();
      setOperands(0, 16'h4200, 16'h4400);
      setOperands(1, 16'h3C00, 16'hBC00);
      setOperands(2, 16'h7C00, 16'h0000);
      setOperands(3, 16'h7BFF, 16'h7BFF);
      applyStimulus(4'b1111, 1'b1);
      got_data.delete();
      got_id.delete();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c < 8) begin
            exp_ready = NUM_REQ'(1) << (c % 4);
            checkOutput("t2_grant", 32'(req_ready), 32'(exp_ready));
         end
         if (rsp_valid) begin
            got_data.push_back(rsp_data);
            got_id.push_back(rsp_id);
         end
         stepCycle();
         if (c == 7) applyStimulus(4'b0000, 1'b1);
      end
      checkOutput("t2_rsp_count", 32'(got_data.size()), 32'd8);
      for (int k = 0; k < 8 && k < got_data.size(); k++) begin
         checkOutput("t2_rsp_data", 32'(got_data[k]), 32'(exp_data[k % 4]));
         checkOutput("t2_rsp_id", 32'(got_id[k]), 32'(k % 4));
      end

      // Test 3: backpressure fills exactly RSP_DEPTH credits, release drains in order
      applyStimulus(4'b1111, 1'b0);
      xfers = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready != '0) xfers++;
         stepCycle();
      end
      checkOutput("t3_transfers", 32'(xfers), 32'(RSP_DEPTH));
      @(negedge clk);
      checkOutput("t3_blocked_ready", 32'(req_ready), 32'd0);
      stepCycle();
      applyStimulus(4'b1111, 1'b1);
      got_data.delete();
      got_id.delete();
      resumed = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got_data.push_back(rsp_data);
            got_id.push_back(rsp_id);
         end
         if (req_ready != '0) resumed = 1'b1;
         stepCycle();
         if (c == 29) applyStimulus(4'b0000, 1'b1);
      end
      checkOutput("t3_issue_resumed", 32'(resumed), 32'd1);
      checkOutput("t3_rsp_at_least_depth", 32'(got_data.size() >= RSP_DEPTH), 32'd1);
      for (int k = 0; k < RSP_DEPTH && k < got_data.size(); k++) begin
         checkOutput("t3_rsp_data", 32'(got_data[k]), 32'(exp_data[k % 4]));
         checkOutput("t3_rsp_id", 32'(got_id[k]), 32'(k % 4));
      end

      // Test 4: one-cycle rsp_ready pulses against a full FIFO
      applyStimulus(4'b1111, 1'b0);
      for (int c = 0; c < 20; c++) stepCycle();
      @(negedge clk);
      checkOutput("t4_fifo_full", 32'(u_dut.fifo_count), 32'(RSP_DEPTH));
      stepCycle();
      for (int p = 0; p < 3; p++) begin
         applyStimulus(4'b1111, 1'b1);
         stepCycle();
         applyStimulus(4'b1111, 1'b0);
         issues = 0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) issues++;
            stepCycle();
         end
         checkOutput("t4_issues_per_pulse", 32'(issues), 32'd1);
         @(negedge clk);
         checkOutput("t4_fifo_refilled", 32'(u_dut.fifo_count), 32'(RSP_DEPTH));
         stepCycle();
      end
      applyStimulus(4'b0000, 1'b1);
      for (int c = 0; c < 20; c++) stepCycle();

      // Test 5: reset while ops are in flight discards them
      applyStimulus(4'b0111, 1'b1);
      for (int c = 0; c < 3; c++) stepCycle();
      applyStimulus(4'b0000, 1'b1);
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
         stepCycle();
      end
      setOperands(2, 16'h3C00, 16'h3C00);
      applyStimulus(4'b0100, 1'b1);
      @(negedge clk);
      checkOutput("t5_req_ready", 32'(req_ready), 32'h4);
      stepCycle();
      applyStimulus(4'b0000, 1'b1);
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid && !found) begin
            found = 1'b1;
            checkOutput("t5_rsp_data", 32'(rsp_data), 32'h3C00);
            checkOutput("t5_rsp_id", 32'(rsp_id), 32'd2);
         end
         stepCycle();
      end
      checkOutput("t5_rsp_seen", 32'(found), 32'd1);

`ifdef FP16_MUL_ARB_PERF_EN
      // Test 6: 10 issues and 5 blocked cycles
      doReset();
      setOperands(0, 16'h3C00, 16'h4000);
      applyStimulus(4'b0001, 1'b0);
      for (int c = 0; c < 13; c++) stepCycle();
      applyStimulus(4'b0000, 1'b1);
      for (int c = 0; c < 15; c++) stepCycle();
      applyStimulus(4'b0001, 1'b1);
      stepCycle();
      stepCycle();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("t6_perf_issue_cnt", perf_issue_cnt, 32'd10);
      checkOutput("t6_perf_stall_cnt", perf_stall_cnt, 32'd5);
      for (int c = 0; c < 10; c++) stepCycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
